// File: rtl/fir_pkg.sv
// Shared widths, default tap count, FSM state encoding and clog2 helper for the FIR tap sequencer.
package fir_pkg;

    localparam int unsigned FILTER_IN_BITS_DEF = 16;
    localparam int unsigned COEFF_BITS_DEF     = 16;
    localparam int unsigned NUM_TAPS_DEF       = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fir_state_e;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample handshake, coefficient write port and MAC operand bus of the FIR tap sequencer.
interface fir_tap_sequencer_if
    import fir_pkg::*;
#(
    parameter int unsigned FILTER_IN_BITS = FILTER_IN_BITS_DEF,
    parameter int unsigned COEFF_BITS     = COEFF_BITS_DEF,
    parameter int unsigned ADDR_BITS      = clog2(NUM_TAPS_DEF)
);

    logic                      in_valid;
    logic                      in_ready;
    logic [FILTER_IN_BITS-1:0] in_sample;
    logic                      coeff_wr_en;
    logic [ADDR_BITS-1:0]      coeff_wr_addr;
    logic [COEFF_BITS-1:0]     coeff_wr_data;
    logic                      coeff_wr_err;
    logic [FILTER_IN_BITS-1:0] delay_filter_in;
    logic [COEFF_BITS-1:0]     coeff;
    logic                      clk_enable;
    logic                      phase_min;
    logic                      result_valid;
    logic                      busy;

    modport master (
        output in_valid, in_sample, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        input  in_ready, coeff_wr_err, delay_filter_in, coeff, clk_enable,
               phase_min, result_valid, busy
    );

    modport slave (
        input  in_valid, in_sample, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        output in_ready, coeff_wr_err, delay_filter_in, coeff, clk_enable,
               phase_min, result_valid, busy
    );

endinterface

// File: rtl/fir_coeff_bank.sv
// N x COEFF_BITS coefficient register file: one synchronous write port, one combinational read port.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int unsigned COEFF_BITS     = COEFF_BITS_DEF,
    parameter int unsigned NUMBER_OF_TAPS = NUM_TAPS_DEF,
    parameter int unsigned ADDR_BITS      = clog2(NUMBER_OF_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [COEFF_BITS-1:0] wr_data,
    output logic                  addr_ok_c,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [COEFF_BITS-1:0] rd_data_c
);

    logic [COEFF_BITS-1:0] coef_q [NUMBER_OF_TAPS];
    logic [COEFF_BITS-1:0] coef_d [NUMBER_OF_TAPS];

    // Addresses at or above the tap count do not exist.
    assign addr_ok_c = 32'(wr_addr) < NUMBER_OF_TAPS;

    // Read port; out-of-range addresses read as zero.
    assign rd_data_c = (32'(rd_addr) < NUMBER_OF_TAPS) ? coef_q[rd_addr] : '0;

    // Next register-file contents.
    always_comb begin
        coef_d = coef_q;
        if (wr_en && addr_ok_c) begin
            coef_d[wr_addr] = wr_data;
        end
    end

    // Coefficient storage, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUMBER_OF_TAPS); i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            coef_q <= coef_d;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Serial FIR tap sequencer: sample ring buffer, pointers and the IDLE/MAC/FLUSH/DONE loop control.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned FILTER_IN_BITS = FILTER_IN_BITS_DEF,
    parameter int unsigned COEFF_BITS     = COEFF_BITS_DEF,
    parameter int unsigned NUMBER_OF_TAPS = NUM_TAPS_DEF
) (
    input logic               clk,
    input logic               rst,
    fir_tap_sequencer_if.slave bus
);

    localparam int unsigned ADDR_BITS = clog2(NUMBER_OF_TAPS);
    localparam logic [ADDR_BITS-1:0] LAST_TAP = ADDR_BITS'(NUMBER_OF_TAPS - 1);

    // Ring index arithmetic modulo N, valid for any N >= 2.
    function automatic logic [ADDR_BITS-1:0] ptr_inc(input logic [ADDR_BITS-1:0] p);
        return (p == LAST_TAP) ? '0 : p + ADDR_BITS'(1);
    endfunction

    function automatic logic [ADDR_BITS-1:0] ptr_dec(input logic [ADDR_BITS-1:0] p);
        return (p == '0) ? LAST_TAP : p - ADDR_BITS'(1);
    endfunction

    fir_state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]      tap_q, tap_d;
    logic [ADDR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FILTER_IN_BITS-1:0] ring_q [NUMBER_OF_TAPS];
    logic [FILTER_IN_BITS-1:0] ring_d [NUMBER_OF_TAPS];

    logic                      in_ready_q, in_ready_d;
    logic                      clk_enable_q, clk_enable_d;
    logic                      phase_min_q, phase_min_d;
    logic [FILTER_IN_BITS-1:0] delay_q, delay_d;
    logic [COEFF_BITS-1:0]     coeff_q, coeff_d;
    logic                      result_valid_q, result_valid_d;
    logic                      busy_q, busy_d;
    logic                      wr_err_q, wr_err_d;

    logic                      ready_state_c;
    logic                      accept_c;
    logic                      wr_ok_c;
    logic                      addr_ok_c;
    logic [ADDR_BITS-1:0]      rd_addr_c;
    logic [COEFF_BITS-1:0]     rd_data_c;
    logic [COEFF_BITS-1:0]     coeff_next_c;

    // Handshake, write qualification and the coefficient needed for the next displayed tap.
    always_comb begin
        ready_state_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
        accept_c      = ready_state_c && bus.in_valid;
        wr_ok_c       = bus.coeff_wr_en && ready_state_c && addr_ok_c;
        rd_addr_c     = (accept_c || (tap_q == LAST_TAP)) ? '0 : tap_q + ADDR_BITS'(1);
        // A write landing in the accept cycle must already feed that loop.
        coeff_next_c  = (wr_ok_c && (bus.coeff_wr_addr == rd_addr_c)) ? bus.coeff_wr_data
                                                                       : rd_data_c;
    end

    fir_coeff_bank #(
        .COEFF_BITS     (COEFF_BITS),
        .NUMBER_OF_TAPS (NUMBER_OF_TAPS),
        .ADDR_BITS      (ADDR_BITS)
    ) u_coeff_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_ok_c),
        .wr_addr   (bus.coeff_wr_addr),
        .wr_data   (bus.coeff_wr_data),
        .addr_ok_c (addr_ok_c),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    // Next state, pointers, ring contents and registered outputs.
    always_comb begin
        state_d        = state_q;
        tap_d          = tap_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        ring_d         = ring_q;
        in_ready_d     = 1'b1;
        clk_enable_d   = 1'b0;
        phase_min_d    = 1'b0;
        delay_d        = '0;
        coeff_d        = '0;
        result_valid_d = 1'b0;
        busy_d         = 1'b0;
        wr_err_d       = bus.coeff_wr_en && !wr_ok_c;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    // Tap 0 is the sample being written, so it bypasses the ring.
                    ring_d[wr_ptr_q] = bus.in_sample;
                    rd_ptr_d         = wr_ptr_q;
                    wr_ptr_d         = ptr_inc(wr_ptr_q);
                    tap_d            = '0;
                    state_d          = ST_MAC;
                    in_ready_d       = 1'b0;
                    busy_d           = 1'b1;
                    clk_enable_d     = 1'b1;
                    phase_min_d      = 1'b1;
                    delay_d          = bus.in_sample;
                    coeff_d          = coeff_next_c;
                end
            end
            ST_MAC: begin
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
                if (tap_q == LAST_TAP) begin
                    state_d     = ST_FLUSH;
                    phase_min_d = 1'b1;
                    delay_d     = delay_q;
                    coeff_d     = coeff_q;
                end else begin
                    tap_d        = tap_q + ADDR_BITS'(1);
                    rd_ptr_d     = ptr_dec(rd_ptr_q);
                    delay_d      = ring_q[ptr_dec(rd_ptr_q)];
                    coeff_d      = coeff_next_c;
                    clk_enable_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d        = ST_DONE;
                result_valid_d = 1'b1;
                busy_d         = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, ring and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tap_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            for (int i = 0; i < int'(NUMBER_OF_TAPS); i++) begin
                ring_q[i] <= '0;
            end
            in_ready_q     <= 1'b1;
            clk_enable_q   <= 1'b0;
            phase_min_q    <= 1'b0;
            delay_q        <= '0;
            coeff_q        <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            wr_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ring_q         <= ring_d;
            in_ready_q     <= in_ready_d;
            clk_enable_q   <= clk_enable_d;
            phase_min_q    <= phase_min_d;
            delay_q        <= delay_d;
            coeff_q        <= coeff_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            wr_err_q       <= wr_err_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.clk_enable      = clk_enable_q;
    assign bus.phase_min       = phase_min_q;
    assign bus.delay_filter_in = delay_q;
    assign bus.coeff           = coeff_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.busy            = busy_q;
    assign bus.coeff_wr_err    = wr_err_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed plus random stimulus for the FIR tap sequencer (N=5) against a timeline reference model.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned FW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned AW = clog2(N);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.FILTER_IN_BITS(FW), .COEFF_BITS(CW), .ADDR_BITS(AW)) bus ();

    fir_tap_sequencer #(
        .FILTER_IN_BITS (FW),
        .COEFF_BITS     (CW),
        .NUMBER_OF_TAPS (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since the last accept (0 = idle), sample history newest first,
    // coefficient table, and the operand list snapshotted when a loop starts.
    int              phase;
    logic [FW-1:0]   hist [$];
    logic [CW-1:0]   mcoef [N];
    logic [FW-1:0]   lop_d [N];
    logic [CW-1:0]   lop_c [N];
    logic            exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s phase=%0d observed=%h expected=%h", tag, phase, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        logic          e_ready, e_ce, e_pm, e_rv, e_busy;
        logic [FW-1:0] e_d;
        logic [CW-1:0] e_c;
        e_ready = 1'b1; e_ce = 1'b0; e_pm = 1'b0; e_rv = 1'b0; e_busy = 1'b0;
        e_d = '0; e_c = '0;
        if (phase >= 1 && phase <= int'(N)) begin
            e_ready = 1'b0; e_busy = 1'b1; e_ce = 1'b1;
            e_pm = (phase == 1);
            e_d = lop_d[phase-1];
            e_c = lop_c[phase-1];
        end else if (phase == int'(N) + 1) begin
            e_ready = 1'b0; e_busy = 1'b1; e_pm = 1'b1;
            e_d = lop_d[N-1];
            e_c = lop_c[N-1];
        end else if (phase == int'(N) + 2) begin
            e_rv = 1'b1; e_busy = 1'b1;
        end
        chk("in_ready",        32'(bus.in_ready),        32'(e_ready));
        chk("clk_enable",      32'(bus.clk_enable),      32'(e_ce));
        chk("phase_min",       32'(bus.phase_min),       32'(e_pm));
        chk("delay_filter_in", 32'(bus.delay_filter_in), 32'(e_d));
        chk("coeff",           32'(bus.coeff),           32'(e_c));
        chk("result_valid",    32'(bus.result_valid),    32'(e_rv));
        chk("busy",            32'(bus.busy),            32'(e_busy));
        chk("coeff_wr_err",    32'(bus.coeff_wr_err),    32'(exp_err));
    endtask

    // One clock: drive inputs, advance the model by the same edge, check after the edge.
    task automatic cyc(input logic v, input logic [FW-1:0] s, input logic we,
                       input logic [AW-1:0] wa, input logic [CW-1:0] wd);
        logic ready, ok;
        bus.in_valid      = v;
        bus.in_sample     = s;
        bus.coeff_wr_en   = we;
        bus.coeff_wr_addr = wa;
        bus.coeff_wr_data = wd;
        ready   = (phase == 0) || (phase == int'(N) + 2);
        ok      = we && ready && (32'(wa) < N);
        exp_err = we && !ok;
        if (ok) mcoef[wa] = wd;
        if (ready && v) begin
            hist.push_front(s);
            if (hist.size() > int'(N)) hist.delete(int'(N));
            for (int k = 0; k < int'(N); k++) begin
                lop_d[k] = (k < hist.size()) ? hist[k] : '0;
                lop_c[k] = mcoef[k];
            end
            phase = 1;
        end else if (phase == int'(N) + 2) begin
            phase = 0;
        end else if (phase != 0) begin
            phase++;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset applied between edges; checked immediately and after one edge.
    task automatic do_reset();
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_sample     = '0;
        bus.coeff_wr_en   = 1'b0;
        bus.coeff_wr_addr = '0;
        bus.coeff_wr_data = '0;
        #1;
        phase   = 0;
        exp_err = 1'b0;
        hist.delete();
        for (int k = 0; k < int'(N); k++) mcoef[k] = '0;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Load coefficients 1..N while idle.
        for (int k = 0; k < int'(N); k++) cyc(1'b0, '0, 1'b1, AW'(k), CW'(k + 1));

        // First loop sees zeros in unfilled slots; second sees (20,c0),(10,c1),(0,..).
        cyc(1'b1, 16'd10, 1'b0, '0, '0); idle(N + 2);
        cyc(1'b1, 16'd20, 1'b0, '0, '0); idle(N + 2);

        // Seven samples back-to-back with in_valid held high: ring wraps.
        for (int i = 1; i <= 7; i++) begin
            for (int c = 0; c < int'(N) + 2; c++) cyc(1'b1, FW'(i), 1'b0, '0, '0);
        end
        idle(N + 2);

        // Write during a loop is dropped; out-of-range addresses are dropped.
        cyc(1'b1, 16'd33, 1'b0, '0, '0);
        cyc(1'b0, '0, 1'b1, 3'd0, 16'h7777);
        cyc(1'b0, '0, 1'b1, 3'd1, 16'h6666);
        idle(N);
        cyc(1'b0, '0, 1'b1, 3'd5, 16'h1234);
        cyc(1'b0, '0, 1'b1, 3'd7, 16'h4321);
        idle(1);

        // Coefficient write and sample accept in the same cycle.
        cyc(1'b1, 16'd44, 1'b1, 3'd0, 16'h0BAD); idle(N + 2);
        cyc(1'b1, 16'hFFFF, 1'b1, 3'd4, 16'h8000); idle(N + 2);

        // Reset while tap 2 is on the bus: loop abandoned, ring and coefficients cleared.
        cyc(1'b1, 16'd55, 1'b0, '0, '0);
        idle(2);
        do_reset();
        idle(N + 3);
        for (int k = 0; k < int'(N); k++) cyc(1'b0, '0, 1'b1, AW'(k), CW'(16'h0100 + k));
        cyc(1'b1, 16'd66, 1'b0, '0, '0); idle(N + 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), FW'($urandom),
                ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)), CW'($urandom));
        end
        idle(N + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
